// File: rtl/lifo_stack.sv
// Parametrised LIFO with push/pop/peek/replace and error pulses; optional high-water mark via LIFO_STACK_WATERMARK_EN.
// Results registered, 1-cycle latency; accepts a request every cycle, never stalls, rejects with err instead.
module lifo_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 10,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iv,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             ov,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
`ifdef LIFO_STACK_WATERMARK_EN
  output logic [CNT_W-1:0] hwm,
  input  logic             hwm_clr,
`endif
  output logic             err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    OP_PUSH    = 2'b00,
    OP_POP     = 2'b01,
    OP_PEEK    = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             mem_we;
  logic [IDX_W-1:0] mem_wa;
  logic             rd_vld;
  logic             rej;
  op_e              cur_op;

  assign cur_op  = op_e'(op);
  assign top_idx = IDX_W'(cnt - 1'b1);
  assign wr_idx  = IDX_W'(cnt);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;

  always_comb begin
    cnt_nxt = cnt;
    mem_we  = 1'b0;
    mem_wa  = wr_idx;
    rd_vld  = 1'b0;
    rej     = 1'b0;
    if (iv) begin
      unique case (cur_op)
        OP_PUSH: begin
          if (full) begin
            rej = 1'b1;
          end else begin
            mem_we  = 1'b1;
            cnt_nxt = cnt + 1'b1;
          end
        end
        OP_POP: begin
          if (empty) begin
            rej = 1'b1;
          end else begin
            rd_vld  = 1'b1;
            cnt_nxt = cnt - 1'b1;
          end
        end
        OP_PEEK: begin
          if (empty) rej = 1'b1;
          else       rd_vld = 1'b1;
        end
        OP_REPLACE: begin
          // Old top is read out on the same edge the new word overwrites it.
          if (empty) begin
            rej = 1'b1;
          end else begin
            rd_vld = 1'b1;
            mem_we = 1'b1;
            mem_wa = top_idx;
          end
        end
        default: rej = 1'b0;
      endcase
    end
  end

  // Storage is not reset; a request coinciding with reset must not write.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_wa] <= in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      out <= '0;
      ov  <= 1'b0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ov  <= rd_vld;
      err <= rej;
      if (rd_vld) out <= mem[top_idx];
    end
  end

`ifdef LIFO_STACK_WATERMARK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hwm <= '0;
    end else if (hwm_clr) begin
      hwm <= cnt_nxt;
    end else if (cnt_nxt > hwm) begin
      hwm <= cnt_nxt;
    end
  end
`else
  // Without the watermark no extra state exists.
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Randomised scoreboard bench for lifo_stack (DEPTH=4, WIDTH=16) against a queue-based stack model.
module tb_lifo_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             iv;
  logic [1:0]       op;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             ov;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             err;
`ifdef LIFO_STACK_WATERMARK_EN
  logic [CNT_W-1:0] hwm;
  logic             hwm_clr;
`endif

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .iv     (iv),
    .op     (op),
    .in     (in),
    .out    (out),
    .ov     (ov),
    .full   (full),
    .empty  (empty),
    .count  (count),
`ifdef LIFO_STACK_WATERMARK_EN
    .hwm    (hwm),
    .hwm_clr(hwm_clr),
`endif
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             ov;
    logic             err;
    logic [WIDTH-1:0] out;
    int               cnt;
    int               hwm;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] stk[$];
  logic [WIDTH-1:0] m_out;
  int               m_hwm;
  int               checks;
  int               errors;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and enqueue what the stack must show after the edge.
  task automatic step(input logic rst, input logic v, input logic [1:0] o,
                      input logic [WIDTH-1:0] d, input logic clr);
    exp_t e;
    @(negedge clk);
    reset = rst;
    iv    = v;
    op    = o;
    in    = d;
`ifdef LIFO_STACK_WATERMARK_EN
    hwm_clr = clr;
`endif
    e.ov  = 1'b0;
    e.err = 1'b0;
    if (rst) begin
      stk.delete();
      m_out = '0;
      m_hwm = 0;
    end else begin
      if (v) begin
        case (o)
          2'b00: if (stk.size() == DEPTH) e.err = 1'b1; else stk.push_back(d);
          2'b01: if (stk.size() == 0) e.err = 1'b1;
                 else begin m_out = stk.pop_back(); e.ov = 1'b1; end
          2'b10: if (stk.size() == 0) e.err = 1'b1;
                 else begin m_out = stk[$]; e.ov = 1'b1; end
          default: if (stk.size() == 0) e.err = 1'b1;
                   else begin m_out = stk[$]; stk[$] = d; e.ov = 1'b1; end
        endcase
      end
      if (clr || stk.size() > m_hwm) m_hwm = stk.size();
    end
    e.out = m_out;
    e.cnt = stk.size();
    e.hwm = m_hwm;
    sb.push_back(e);
  endtask

  task automatic push(input logic [WIDTH-1:0] d); step(1'b0, 1'b1, 2'b00, d, 1'b0); endtask
  task automatic pop();                           step(1'b0, 1'b1, 2'b01, '0, 1'b0); endtask
  task automatic peek();                          step(1'b0, 1'b1, 2'b10, '0, 1'b0); endtask
  task automatic repl(input logic [WIDTH-1:0] d); step(1'b0, 1'b1, 2'b11, d, 1'b0); endtask
  task automatic rst_cyc();                       step(1'b1, 1'b0, 2'b00, '0, 1'b0); endtask
  task automatic idle();                          step(1'b0, 1'b0, 2'b00, '0, 1'b0); endtask

  // Monitor: one expected record per driven cycle, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ov", int'(ov), int'(e.ov));
      chk("err", int'(err), int'(e.err));
      chk("out", int'(out), int'(e.out));
      chk("count", int'(count), e.cnt);
      chk("full", int'(full), int'(e.cnt == DEPTH));
      chk("empty", int'(empty), int'(e.cnt == 0));
`ifdef LIFO_STACK_WATERMARK_EN
      chk("hwm", int'(hwm), e.hwm);
`endif
    end
  end

  initial begin
    int wait_cyc;
    checks = 0;
    errors = 0;
    m_out  = '0;
    m_hwm  = 0;
    reset  = 1'b1;
    iv     = 1'b0;
    op     = 2'b00;
    in     = '0;
`ifdef LIFO_STACK_WATERMARK_EN
    hwm_clr = 1'b0;
`endif
    rst_cyc(); rst_cyc();

    // LIFO order
    push(16'h0011); push(16'h0022); push(16'h0033);
    pop(); pop(); pop(); idle();

    // Fill, overflow, pop
    push(16'd1); push(16'd2); push(16'd3); push(16'd4);
    push(16'd5); pop(); idle();

    // Underflow on every read-type op
    rst_cyc();
    pop(); peek(); repl(16'h00AA); idle();

    // Peek and replace
    push(16'h1234); peek(); peek(); repl(16'h5678); pop(); idle();

    // Reset wins over a same-cycle request
    push(16'd7); push(16'd8);
    step(1'b1, 1'b1, 2'b00, 16'd9, 1'b0);
    pop(); idle();

    // Push after pop reuses the freed slot; replace when full
    push(16'hA1); push(16'hA2); pop(); push(16'hA3); pop(); pop();
    push(16'd1); push(16'd2); push(16'd3); push(16'd4); repl(16'hBEEF); pop(); pop();

`ifdef LIFO_STACK_WATERMARK_EN
    rst_cyc();
    push(16'd1); push(16'd2); push(16'd3); pop(); pop();
    step(1'b0, 1'b0, 2'b00, '0, 1'b1);
    push(16'd4); idle();
    step(1'b0, 1'b1, 2'b00, 16'd5, 1'b1);
`endif

    // Random traffic with occasional resets
    rst_cyc();
    for (int i = 0; i < 600; i++) begin
      logic r, v, c;
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 19) == 0);
      step(r, v, 2'($urandom_range(0, 3)), WIDTH'($urandom), c);
    end
    idle();

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected records left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
